adder4_result_align: RTL and testbench

ADDER4_RESULT_ALIGN -- requirements
Module: adder4_result_align

---
 rtl/adder4_pkg.sv | 13 +
 rtl/adder4_result_align_if.sv | 26 ++
 rtl/adder4_align_fifo.sv | 65 ++++++
 rtl/adder4_result_align.sv | 86 ++++++++
 tb/tb_adder4_result_align.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/adder4_pkg.sv
// Shared widths and the aligned result record for the skewed 4-bit adder
// result aligner.
package adder4_pkg;

    localparam int ADD_W = 4;
    localparam int SKEW  = ADD_W - 1;

    typedef struct packed {
        logic             cout;
        logic [ADD_W-1:0] sum;
    } align_word_t;

endpackage

// File: rtl/adder4_result_align_if.sv
// Upstream adder bus plus downstream result stream of the aligner.
// Output handshake: a word transfers on a rising edge where OUT_VALID and OUT_READY are both high.
interface adder4_result_align_if;
    import adder4_pkg::*;

    logic             IN_VALID;
    logic [ADD_W-1:0] SUM;
    logic             COUT;
    logic             IN_READY;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [ADD_W-1:0] OUT_SUM;
    logic             OUT_COUT;
    logic             OVF;

    modport master (
        output IN_VALID, SUM, COUT, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_SUM, OUT_COUT, OVF
    );

    modport slave (
        input  IN_VALID, SUM, COUT, OUT_READY,
        output IN_READY, OUT_VALID, OUT_SUM, OUT_COUT, OVF
    );

endinterface

// File: rtl/adder4_align_fifo.sv
// Synchronous FIFO of aligned words; a push while full is dropped unless a
// pop happens in the same cycle.
module adder4_align_fifo
    import adder4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  align_word_t                i_wdata,
    input  logic                       i_pop,
    output align_word_t                o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    align_word_t          r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_do_push;
    logic                 w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Head reads as zero when empty so the output bus is clean after reset.
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/adder4_result_align.sv
// Realigns the bit-skewed output of a carry-pipelined 4-bit ripple adder into
// whole words and buffers them in a credit-controlled output FIFO.
module adder4_result_align
    import adder4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 CK,
    input  logic                 RST_N,
    adder4_result_align_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int CRD_W = CNT_W + 1;

    logic                r_v1;
    logic                r_v2;
    logic                r_v3;
    logic [SKEW-1:0]     r_d0;
    logic [SKEW-2:0]     r_d1;
    logic [SKEW-3:0]     r_d2;
    logic                r_ovf;

    align_word_t         w_word;
    align_word_t         w_head;
    logic                w_full;
    logic                w_empty;
    logic [CNT_W-1:0]    w_count;
    logic                w_pop;
    logic [CRD_W-1:0]    w_pending;

    // Bit k of an operation arrives k cycles late; delay lower bits to meet bit 3.
    always_ff @(posedge CK) begin
        if (!RST_N) begin
            r_v1  <= 1'b0;
            r_v2  <= 1'b0;
            r_v3  <= 1'b0;
            r_d0  <= '0;
            r_d1  <= '0;
            r_d2  <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_v1  <= bus.IN_VALID;
            r_v2  <= r_v1;
            r_v3  <= r_v2;
            r_d0  <= {r_d0[SKEW-2:0], bus.SUM[0]};
            r_d1  <= {r_d1[SKEW-3:0], bus.SUM[1]};
            r_d2  <= bus.SUM[2];
            if (r_v3 && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        w_word      = '0;
        w_word.sum  = {bus.SUM[3], r_d2[0], r_d1[SKEW-2], r_d0[SKEW-1]};
        w_word.cout = bus.COUT;
    end

    assign w_pop = !w_empty && bus.OUT_READY;

    adder4_align_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CK),
        .i_rst_n (RST_N),
        .i_push  (r_v3),
        .i_wdata (w_word),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Words still in the tag pipeline already own a FIFO slot.
    assign w_pending = CRD_W'(w_count) + CRD_W'(r_v1) + CRD_W'(r_v2) + CRD_W'(r_v3);

    assign bus.IN_READY  = (w_pending < CRD_W'(DEPTH));
    assign bus.OUT_VALID = !w_empty;
    assign bus.OUT_SUM   = w_head.sum;
    assign bus.OUT_COUT  = w_head.cout;
    assign bus.OVF       = r_ovf;

endmodule

// File: tb/tb_adder4_result_align.sv
// Scoreboard bench for adder4_result_align: a skewed-adder driver, a reference
// pipeline/FIFO model feeding an expected queue, and per-cycle output checks.
module tb_adder4_result_align;
    import adder4_pkg::*;

    localparam int DEPTH = 4;

    logic CK    = 1'b0;
    logic RST_N = 1'b0;

    always #5 CK = ~CK;

    adder4_result_align_if bus ();

    adder4_result_align #(
        .DEPTH (DEPTH)
    ) dut (
        .CK    (CK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [4:0] exp_q[$];
    logic       exp_ovf = 1'b0;
    logic [3:1] mp_v = '0;
    logic [4:0] mp_w [1:3];
    logic [4:0] hist [0:3];
    int         accepted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Upstream adder model: SUM[k] carries bit k of the op issued k cycles ago.
    task automatic drive(input logic in_v, input logic [4:0] val, input logic out_rdy);
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = in_v ? val : 5'($urandom);
        bus.IN_VALID  = in_v;
        bus.OUT_READY = out_rdy;
        bus.SUM       = {hist[3][3], hist[2][2], hist[1][1], hist[0][0]};
        bus.COUT      = hist[3][4];
    endtask

    task automatic check_outputs();
        int pending;
        pending = exp_q.size() + int'(mp_v[1]) + int'(mp_v[2]) + int'(mp_v[3]);
        check("out_valid", bus.OUT_VALID, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("out_word", {bus.OUT_COUT, bus.OUT_SUM}, exp_q[0]);
        end
        check("in_ready", bus.IN_READY, pending < DEPTH);
        check("ovf", bus.OVF, exp_ovf);
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", bus.OUT_VALID, 1'b0);
        check("rst_out_sum", bus.OUT_SUM, 4'h0);
        check("rst_out_cout", bus.OUT_COUT, 1'b0);
        check("rst_in_ready", bus.IN_READY, 1'b1);
        check("rst_ovf", bus.OVF, 1'b0);
    endtask

    // One cycle: check outputs, advance the model across the edge, drive inputs.
    task automatic step(input logic in_v, input logic [4:0] val, input logic out_rdy);
        check_outputs();
        if (exp_q.size() != 0 && out_rdy) begin
            void'(exp_q.pop_front());
        end
        if (mp_v[3]) begin
            if (exp_q.size() == DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back(mp_w[3]);
        end
        mp_v[3] = mp_v[2];
        mp_w[3] = mp_w[2];
        mp_v[2] = mp_v[1];
        mp_w[2] = mp_w[1];
        mp_v[1] = in_v;
        mp_w[1] = val;
        drive(in_v, val, out_rdy);
        @(posedge CK);
        @(negedge CK);
    endtask

    task automatic do_reset(input int n);
        RST_N = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 5'($urandom), 1'b1);
            @(posedge CK);
            @(negedge CK);
        end
        RST_N = 1'b1;
        exp_q.delete();
        mp_v    = '0;
        exp_ovf = 1'b0;
    endtask

    task automatic idle(input int n, input logic out_rdy);
        for (int i = 0; i < n; i++) step(1'b0, 5'h0, out_rdy);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) hist[i] = '0;

        do_reset(2);
        check_reset_state();

        // Single op: sum 4'b1000, carry 0.
        step(1'b1, 5'b01000, 1'b1);
        idle(6, 1'b1);

        // Streaming 0..7 back to back.
        for (int i = 0; i < 8; i++) step(1'b1, 5'(i), 1'b1);
        idle(6, 1'b1);

        // Streaming with random sums and carries.
        for (int i = 0; i < 8; i++) step(1'b1, 5'($urandom), 1'b1);
        idle(6, 1'b1);

        // Backpressure: issue only on credit with the consumer stalled.
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            logic rdy;
            rdy = bus.IN_READY;
            if (rdy) accepted++;
            step(rdy, 5'(i + 9), 1'b0);
        end
        check("accepted", accepted, 4);
        idle(8, 1'b1);

        // Overflow: five forced issues into a stalled four-entry FIFO.
        for (int i = 0; i < 5; i++) step(1'b1, 5'(i + 20), 1'b0);
        idle(5, 1'b0);
        idle(8, 1'b1);
        check("ovf_sticky", bus.OVF, 1'b1);

        do_reset(1);
        check_reset_state();

        // Full FIFO receiving pushes in the same cycles it is popped.
        for (int i = 0; i < 4; i++) step(1'b1, 5'(i + 1), 1'b0);
        idle(3, 1'b0);
        step(1'b1, 5'h15, 1'b0);
        step(1'b1, 5'h16, 1'b0);
        step(1'b1, 5'h17, 1'b0);
        step(1'b1, 5'h18, 1'b1);
        idle(3, 1'b1);
        check("full_pushpop_ovf", bus.OVF, 1'b0);
        idle(6, 1'b1);

        // Reset with two words queued and two in the pipeline.
        step(1'b1, 5'h1a, 1'b0);
        step(1'b1, 5'h1b, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 5'h1c, 1'b0);
        step(1'b1, 5'h1d, 1'b0);
        do_reset(1);
        check_reset_state();
        idle(8, 1'b1);

        // Random traffic with credit-respecting issue and random stalls.
        for (int i = 0; i < 60; i++) begin
            logic iv;
            iv = bus.IN_READY && ($urandom_range(0, 3) != 0);
            step(iv, 5'($urandom), $urandom_range(0, 3) != 0);
        end
        idle(10, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
